// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between requesters A and B.
// Tenure is capped at MAX_BURST consecutive grants while the other side waits.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  logic [1:0]    owner;
  logic          prev_b;
  logic [CW-1:0] burst_cnt;
  logic          vld_a_p1;
  logic          vld_b_p1;
  logic          pick_a;
  logic          pick_b;
  logic          at_cap;

  assign at_cap = (burst_cnt == BURST_MAX);

  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    case (owner)
      OWN_A: begin
        if (a_req && !(b_req && at_cap)) pick_a = 1'b1;
        else if (b_req)                  pick_b = 1'b1;
      end
      OWN_B: begin
        if (b_req && !(a_req && at_cap)) pick_b = 1'b1;
        else if (a_req)                  pick_a = 1'b1;
      end
      default: begin
        if (a_req && b_req) begin
          pick_a = prev_b;
          pick_b = !prev_b;
        end else begin
          pick_a = a_req;
          pick_b = b_req;
        end
      end
    endcase
  end

  assign a_gnt = pick_a && !reset;
  assign b_gnt = pick_b && !reset;

  // Stage p0: granted command steered onto the memory port
  always_comb begin
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    if (a_gnt) begin
      mem_write_enable = a_we;
      mem_address      = a_addr;
      mem_data_in      = a_wdata;
    end else if (b_gnt) begin
      mem_write_enable = b_we;
      mem_address      = b_addr;
      mem_data_in      = b_wdata;
    end
  end

  // burst_cnt saturates so a lone requester can stream indefinitely yet yield at once
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_NONE;
      prev_b    <= 1'b1;
      burst_cnt <= '0;
      vld_a_p1  <= 1'b0;
      vld_b_p1  <= 1'b0;
    end else begin
      vld_a_p1 <= a_gnt && !a_we;
      vld_b_p1 <= b_gnt && !b_we;
      if (a_gnt) begin
        if (owner == OWN_A) begin
          if (!at_cap) burst_cnt <= burst_cnt + CW'(1);
        end else begin
          owner     <= OWN_A;
          prev_b    <= 1'b0;
          burst_cnt <= CW'(1);
        end
      end else if (b_gnt) begin
        if (owner == OWN_B) begin
          if (!at_cap) burst_cnt <= burst_cnt + CW'(1);
        end else begin
          owner     <= OWN_B;
          prev_b    <= 1'b1;
          burst_cnt <= CW'(1);
        end
      end else begin
        owner     <= OWN_NONE;
        burst_cnt <= '0;
      end
    end
  end

  // Stage p1: read data returns from the memory's output register
  assign a_rvalid = vld_a_p1 && !reset;
  assign b_rvalid = vld_b_p1 && !reset;
  assign a_rdata  = mem_data_out;
  assign b_rdata  = mem_data_out;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: two instances (MAX_BURST 4 and 1), each
// wired to a behavioural 1024x8 single-port memory with a registered read port.
module tb_memory_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [9:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write_enable;
  logic [7:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
  logic [9:0] mem_address;

  logic       s_a_req = 1'b0, s_a_we = 1'b0, s_b_req = 1'b0, s_b_we = 1'b0;
  logic [9:0] s_a_addr = '0, s_b_addr = '0;
  logic [7:0] s_a_wdata = '0, s_b_wdata = '0;
  logic       s_a_gnt, s_b_gnt, s_a_rvalid, s_b_rvalid, s_mem_write_enable;
  logic [7:0] s_a_rdata, s_b_rdata, s_mem_data_in, s_mem_data_out;
  logic [9:0] s_mem_address;

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  int n_cmp = 0;
  int n_err = 0;

  memory_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .MAX_BURST(4)) u0 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out));

  memory_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .MAX_BURST(1)) u1 (
    .clk(clk), .reset(reset),
    .a_req(s_a_req), .a_we(s_a_we), .a_addr(s_a_addr), .a_wdata(s_a_wdata),
    .b_req(s_b_req), .b_we(s_b_we), .b_addr(s_b_addr), .b_wdata(s_b_wdata),
    .a_gnt(s_a_gnt), .b_gnt(s_b_gnt), .a_rvalid(s_a_rvalid), .b_rvalid(s_b_rvalid),
    .a_rdata(s_a_rdata), .b_rdata(s_b_rdata),
    .mem_write_enable(s_mem_write_enable), .mem_address(s_mem_address),
    .mem_data_in(s_mem_data_in), .mem_data_out(s_mem_data_out));

  always #5 clk = ~clk;

  // Memory preload: word i holds i ^ 0x5A, so 0x010 -> 0x4A and 0x020 -> 0x7A
  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem0[k] <= 8'(k) ^ 8'h5A;
      mem1[k] <= 8'h00;
    end
  end

  always @(posedge clk) begin
    if (mem_write_enable) mem0[mem_address] <= mem_data_in;
    else                  mem_data_out <= mem0[mem_address];
    if (s_mem_write_enable) mem1[s_mem_address] <= s_mem_data_in;
    else                    s_mem_data_out <= mem1[s_mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] t_addr [6];
  logic [7:0] t_data [6];

  initial begin
    bit ea, pa;
    int ia, ib;
    t_addr = '{10'h100, 10'h101, 10'h102, 10'h200, 10'h201, 10'h202};
    t_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // 1: reset state, then write/read 0x3FF on A
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h3FF; a_wdata = 8'hA5;
    @(negedge clk);
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_mwe", 32'(mem_write_enable), 0);
    chk("rst_maddr", 32'(mem_address), 0);
    chk("rst_mdin", 32'(mem_data_in), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    nxt(); reset = 1'b0;
    @(negedge clk);
    chk("t1_wr_gnt", 32'(a_gnt), 1);
    chk("t1_wr_mwe", 32'(mem_write_enable), 1);
    chk("t1_wr_addr", 32'(mem_address), 32'h3FF);
    chk("t1_wr_data", 32'(mem_data_in), 32'hA5);
    nxt(); a_we = 1'b0;
    @(negedge clk);
    chk("t1_rd_gnt", 32'(a_gnt), 1);
    chk("t1_rd_mwe", 32'(mem_write_enable), 0);
    chk("t1_wr_no_rvalid", 32'(a_rvalid), 0);
    nxt(); a_req = 1'b0;
    @(negedge clk);
    chk("t1_rvalid", 32'(a_rvalid), 1);
    chk("t1_rdata", 32'(a_rdata), 32'hA5);
    chk("t1_b_rvalid", 32'(b_rvalid), 0);
    chk("t1_idle_addr", 32'(mem_address), 0);
    nxt();

    // 2: both read continuously -> AAAABBBBAAAA
    reset = 1'b1; nxt(); reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h020;
    for (int i = 0; i < 12; i++) begin
      ea = ((i / 4) % 2) == 0;
      pa = (((i - 1) / 4) % 2) == 0;
      @(negedge clk);
      chk("t2_a_gnt", 32'(a_gnt), 32'(ea));
      chk("t2_b_gnt", 32'(b_gnt), 32'(!ea));
      chk("t2_addr", 32'(mem_address), ea ? 32'h010 : 32'h020);
      if (i > 0) begin
        chk("t2_a_rvalid", 32'(a_rvalid), 32'(pa));
        chk("t2_b_rvalid", 32'(b_rvalid), 32'(!pa));
        chk("t2_rdata", 32'(mem_data_out), pa ? 32'h4A : 32'h7A);
      end
      nxt();
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("t2_last_a_rvalid", 32'(a_rvalid), 1);
    chk("t2_last_rdata", 32'(a_rdata), 32'h4A);
    nxt();

    // 3: B bursts 10 reads alone, then A preempts at the cap
    reset = 1'b1; nxt(); reset = 1'b0;
    b_req = 1'b1; b_addr = 10'h020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_b_gnt", 32'(b_gnt), 1);
      chk("t3_a_gnt", 32'(a_gnt), 0);
      if (i > 0) chk("t3_b_rdata", 32'(b_rdata), 32'h7A);
      nxt();
    end
    a_req = 1'b1; a_addr = 10'h010;
    @(negedge clk);
    chk("t3_a_preempt", 32'(a_gnt), 1);
    chk("t3_b_held", 32'(b_gnt), 0);
    chk("t3_b_rvalid", 32'(b_rvalid), 1);
    nxt(); a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("t3_a_rvalid", 32'(a_rvalid), 1);
    chk("t3_a_rdata", 32'(a_rdata), 32'h4A);
    chk("t3_b_rvalid_off", 32'(b_rvalid), 0);
    nxt();

    // 4: A drops after two grants, B takes over with no bubble
    reset = 1'b1; nxt(); reset = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    chk("t4_a_gnt1", 32'(a_gnt), 1);
    nxt();
    @(negedge clk);
    chk("t4_a_gnt2", 32'(a_gnt), 1);
    nxt(); a_req = 1'b0;
    @(negedge clk);
    chk("t4_b_gnt", 32'(b_gnt), 1);
    chk("t4_a_gnt_off", 32'(a_gnt), 0);
    chk("t4_b_addr", 32'(mem_address), 32'h020);
    chk("t4_a_rvalid", 32'(a_rvalid), 1);
    nxt(); b_req = 1'b0;
    @(negedge clk);
    chk("t4_b_rvalid", 32'(b_rvalid), 1);
    chk("t4_b_rdata", 32'(b_rdata), 32'h7A);
    chk("t4_a_rvalid_off", 32'(a_rvalid), 0);
    nxt();

    // 5: reset right after a read grant drops the pending rvalid
    reset = 1'b1; nxt(); reset = 1'b0;
    a_req = 1'b1;
    @(negedge clk);
    chk("t5_a_gnt", 32'(a_gnt), 1);
    nxt(); reset = 1'b1; b_req = 1'b1;
    @(negedge clk);
    chk("t5_rst_rvalid", 32'(a_rvalid), 0);
    chk("t5_rst_a_gnt", 32'(a_gnt), 0);
    chk("t5_rst_b_gnt", 32'(b_gnt), 0);
    nxt(); reset = 1'b0;
    @(negedge clk);
    chk("t5_tie_a", 32'(a_gnt), 1);
    chk("t5_tie_b", 32'(b_gnt), 0);
    chk("t5_post_rvalid", 32'(a_rvalid), 0);
    nxt(); a_req = 1'b0; b_req = 1'b0;

    // 6: MAX_BURST=1 writes alternate ABAB, then A reads everything back
    reset = 1'b1; nxt(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ia = (i + 1) / 2;
      ib = i / 2;
      ea = (i % 2) == 0;
      s_a_req = (ia < 3); s_a_we = 1'b1;
      s_a_addr = t_addr[(ia < 3) ? ia : 0]; s_a_wdata = t_data[(ia < 3) ? ia : 0];
      s_b_req = 1'b1; s_b_we = 1'b1;
      s_b_addr = t_addr[3 + ib]; s_b_wdata = t_data[3 + ib];
      @(negedge clk);
      chk("t6_a_gnt", 32'(s_a_gnt), 32'(ea));
      chk("t6_b_gnt", 32'(s_b_gnt), 32'(!ea));
      chk("t6_mwe", 32'(s_mem_write_enable), 1);
      chk("t6_addr", 32'(s_mem_address), 32'(ea ? t_addr[ia] : t_addr[3 + ib]));
      chk("t6_data", 32'(s_mem_data_in), 32'(ea ? t_data[ia] : t_data[3 + ib]));
      nxt();
    end
    s_b_req = 1'b0; s_a_we = 1'b0;
    for (int j = 0; j < 7; j++) begin
      s_a_req = (j < 6);
      s_a_addr = t_addr[(j < 6) ? j : 0];
      @(negedge clk);
      if (j < 6) chk("t6_rd_gnt", 32'(s_a_gnt), 1);
      if (j > 0) begin
        chk("t6_rd_rvalid", 32'(s_a_rvalid), 1);
        chk("t6_rd_data", 32'(s_a_rdata), 32'(t_data[j - 1]));
      end
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
